// File: rtl/axil_slave_regfile_if.sv
// rtl/axil_slave_regfile_if.sv - AXI4-Lite bus bundle between a master and the register-file slave
//
// Ports (signals): aw*, w*, b*, ar*, r* channel payloads and valid/ready pairs.
// Modports: master drives requests and ready for responses; slave mirrors it.
interface axil_slave_regfile_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_slave_regfile.sv
// rtl/axil_slave_regfile.sv - AXI4-Lite slave bank of NUM_REGS byte-strobed 32-bit registers
//
// Ports: aclk, aresetn (async active-low), s_axil (AXI-Lite slave modport),
//        reg_q (flat register contents, reg i at [32*i+31:32*i]).
// Build option: define AXIL_REGFILE_DECERR_EN to answer out-of-range accesses
//               with DECERR instead of SLVERR.
module axil_slave_regfile #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    axil_slave_regfile_if.slave      s_axil,
    output logic [NUM_REGS*32-1:0]   reg_q
);
    localparam int                    IDX_W = $clog2(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] SPAN  = ADDR_WIDTH'(NUM_REGS * 4);
    localparam logic [1:0]            RESP_OKAY = 2'b00;
`ifdef AXIL_REGFILE_DECERR_EN
    localparam logic [1:0]            RESP_ERR  = 2'b11;
`else
    localparam logic [1:0]            RESP_ERR  = 2'b10;
`endif

    // Offset is computed modulo 2^ADDR_WIDTH so addresses below BASE_ADDR wrap out of range.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return off < SPAN;
    endfunction

    function automatic logic [IDX_W-1:0] reg_index(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return IDX_W'(off >> 2);
    endfunction

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [31:0] regs_q [NUM_REGS];

    // ---------------- write channel ----------------
    w_state_t              w_state_q, w_state_d;
    logic                  aw_have_q, aw_have_d, w_have_q, w_have_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  awready_q, awready_d, wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  aw_hs, w_hs, commit;
    logic [ADDR_WIDTH-1:0] cm_addr;
    logic [31:0]           cm_data;
    logic [3:0]            cm_strb;

    assign aw_hs = s_axil.awvalid & awready_q;
    assign w_hs  = s_axil.wvalid & wready_q;
    // A channel arriving this cycle bypasses its holding register so commit is not delayed.
    assign cm_addr = aw_hs ? s_axil.awaddr : awaddr_q;
    assign cm_data = w_hs ? s_axil.wdata : wdata_q;
    assign cm_strb = w_hs ? s_axil.wstrb : wstrb_q;

    always_comb begin
        w_state_d = w_state_q;
        aw_have_d = aw_have_q;
        w_have_d  = w_have_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        commit    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    awaddr_d  = s_axil.awaddr;
                    aw_have_d = 1'b1;
                end
                if (w_hs) begin
                    wdata_d  = s_axil.wdata;
                    wstrb_d  = s_axil.wstrb;
                    w_have_d = 1'b1;
                end
                if ((aw_have_q | aw_hs) && (w_have_q | w_hs)) begin
                    commit    = 1'b1;
                    bvalid_d  = 1'b1;
                    bresp_d   = in_range(cm_addr) ? RESP_OKAY : RESP_ERR;
                    aw_have_d = 1'b0;
                    w_have_d  = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    w_state_d = W_RESP;
                end else begin
                    awready_d = !(aw_have_q | aw_hs);
                    wready_d  = !(w_have_q | w_hs);
                end
            end
            W_RESP: begin
                if (s_axil.bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q <= W_IDLE;
            aw_have_q <= 1'b0;
            w_have_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
        end else begin
            w_state_q <= w_state_d;
            aw_have_q <= aw_have_d;
            w_have_q  <= w_have_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit && in_range(cm_addr)) begin
            for (int k = 0; k < 4; k++) begin
                if (cm_strb[k]) begin
                    regs_q[reg_index(cm_addr)][8*k +: 8] <= cm_data[8*k +: 8];
                end
            end
        end
    end

    // ---------------- read channel ----------------
    r_state_t    r_state_q, r_state_d;
    logic        arready_q, arready_d, rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        ar_hs;

    assign ar_hs = s_axil.arvalid & arready_q;

    // rdata samples regs_q before any same-edge commit lands, so a colliding read sees the old value.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    if (in_range(s_axil.araddr)) begin
                        rdata_d = regs_q[reg_index(s_axil.araddr)];
                        rresp_d = RESP_OKAY;
                    end else begin
                        rdata_d = '0;
                        rresp_d = RESP_ERR;
                    end
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (s_axil.rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign s_axil.awready = awready_q;
    assign s_axil.wready  = wready_q;
    assign s_axil.bvalid  = bvalid_q;
    assign s_axil.bresp   = bresp_q;
    assign s_axil.arready = arready_q;
    assign s_axil.rvalid  = rvalid_q;
    assign s_axil.rdata   = rdata_q;
    assign s_axil.rresp   = rresp_q;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
        assign reg_q[32*i +: 32] = regs_q[i];
    end
endmodule

// File: tb/tb_axil_slave_regfile.sv
// tb/tb_axil_slave_regfile.sv - directed self-checking bench for axil_slave_regfile
module tb_axil_slave_regfile;
    localparam int NR = 16;
`ifdef AXIL_REGFILE_DECERR_EN
    localparam logic [1:0] ERR = 2'b11;
`else
    localparam logic [1:0] ERR = 2'b10;
`endif

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic [NR*32-1:0] reg_q;
    logic [NR*32-1:0] exp_regs = '0;
    int n_assert = 0;
    int n_fail = 0;

    axil_slave_regfile_if #(.ADDR_WIDTH(32)) bus ();

    axil_slave_regfile #(.ADDR_WIDTH(32), .NUM_REGS(NR), .BASE_ADDR(32'h0)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_axil  (bus.slave),
        .reg_q   (reg_q)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [NR*32-1:0] obs, input logic [NR*32-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
        int t;
        bus.awaddr = a; bus.awvalid = 1'b1;
        bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
        @(negedge aclk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        t = 0;
        while (bus.bvalid !== 1'b1 && t < 20) begin
            @(negedge aclk);
            t++;
        end
        chk("wr_bvalid", {511'b0, bus.bvalid}, 1);
        resp = bus.bresp;
        bus.bready = 1'b1;
        @(negedge aclk);
        bus.bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int t;
        bus.araddr = a; bus.arvalid = 1'b1;
        @(negedge aclk);
        bus.arvalid = 1'b0;
        t = 0;
        while (bus.rvalid !== 1'b1 && t < 20) begin
            @(negedge aclk);
            t++;
        end
        chk("rd_rvalid", {511'b0, bus.rvalid}, 1);
        d = bus.rdata;
        resp = bus.rresp;
        bus.rready = 1'b1;
        @(negedge aclk);
        bus.rready = 1'b0;
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0;
        bus.bready = 0; bus.araddr = '0; bus.arvalid = 0; bus.rready = 0;

        // Reset state
        repeat (2) @(negedge aclk);
        chk("rst_awready", {511'b0, bus.awready}, 0);
        chk("rst_arready", {511'b0, bus.arready}, 0);
        chk("rst_bvalid",  {511'b0, bus.bvalid}, 0);
        chk("rst_rvalid",  {511'b0, bus.rvalid}, 0);
        chk("rst_regs", reg_q, '0);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("rel_awready", {511'b0, bus.awready}, 1);
        chk("rel_wready",  {511'b0, bus.wready}, 1);
        chk("rel_arready", {511'b0, bus.arready}, 1);

        // 1: simultaneous AW+W, then read with one-cycle latency
        bus.awaddr = 32'h4; bus.awvalid = 1; bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF; bus.wvalid = 1;
        @(negedge aclk);
        bus.awvalid = 0; bus.wvalid = 0;
        exp_regs[63:32] = 32'hDEADBEEF;
        chk("t1_bvalid", {511'b0, bus.bvalid}, 1);
        chk("t1_bresp", {510'b0, bus.bresp}, 0);
        chk("t1_regs", reg_q, exp_regs);
        bus.bready = 1;
        @(negedge aclk);
        bus.bready = 0;
        chk("t1_bvalid_clr", {511'b0, bus.bvalid}, 0);
        chk("t1_awready_back", {511'b0, bus.awready}, 1);
        bus.araddr = 32'h4; bus.arvalid = 1;
        @(negedge aclk);
        bus.arvalid = 0;
        chk("t1_rvalid", {511'b0, bus.rvalid}, 1);
        chk("t1_rdata", {480'b0, bus.rdata}, 32'hDEADBEEF);
        chk("t1_rresp", {510'b0, bus.rresp}, 0);
        chk("t1_arready_low", {511'b0, bus.arready}, 0);
        bus.rready = 1;
        @(negedge aclk);
        bus.rready = 0;
        chk("t1_rvalid_clr", {511'b0, bus.rvalid}, 0);

        // 2: W three cycles ahead of AW, sparse strobes
        bus.wdata = 32'h11223344; bus.wstrb = 4'b0101; bus.wvalid = 1;
        @(negedge aclk);
        bus.wvalid = 0;
        chk("t2_wready_low", {511'b0, bus.wready}, 0);
        chk("t2_awready_high", {511'b0, bus.awready}, 1);
        chk("t2_no_bvalid", {511'b0, bus.bvalid}, 0);
        repeat (2) @(negedge aclk);
        chk("t2_wready_still_low", {511'b0, bus.wready}, 0);
        chk("t2_regs_before", reg_q, exp_regs);
        bus.awaddr = 32'h8; bus.awvalid = 1;
        @(negedge aclk);
        bus.awvalid = 0;
        exp_regs[95:64] = 32'h00220044;
        chk("t2_bvalid", {511'b0, bus.bvalid}, 1);
        chk("t2_regs", reg_q, exp_regs);
        bus.bready = 1;
        @(negedge aclk);
        bus.bready = 0;

        // Partial strobe over live data, zero strobe, low address bits ignored
        do_write(32'h4, 32'hAA00_0000, 4'b1000, resp);
        exp_regs[63:32] = 32'hAAADBEEF;
        chk("strb_hi_resp", {510'b0, resp}, 0);
        chk("strb_hi_regs", reg_q, exp_regs);
        do_write(32'h4, 32'hFFFF_FFFF, 4'b0000, resp);
        chk("strb0_resp", {510'b0, resp}, 0);
        chk("strb0_regs", reg_q, exp_regs);
        do_read(32'h9, rd, resp);
        chk("lowbits_rdata", {480'b0, rd}, 32'h00220044);

        // 3: out-of-range write and read
        do_write(32'h40, 32'hFFFF_FFFF, 4'hF, resp);
        chk("oor_bresp", {510'b0, resp}, ERR);
        chk("oor_regs", reg_q, exp_regs);
        do_read(32'h40, rd, resp);
        chk("oor_rdata", {480'b0, rd}, 0);
        chk("oor_rresp", {510'b0, resp}, ERR);

        // 4: bready stalled five cycles, extra AW must wait
        bus.awaddr = 32'h14; bus.awvalid = 1; bus.wdata = 32'h12345678; bus.wstrb = 4'hF; bus.wvalid = 1;
        @(negedge aclk);
        bus.wvalid = 0;
        bus.awaddr = 32'h18;
        exp_regs[191:160] = 32'h12345678;
        for (int i = 0; i < 5; i++) begin
            chk("t4_bvalid_hold", {511'b0, bus.bvalid}, 1);
            chk("t4_bresp_hold", {510'b0, bus.bresp}, 0);
            chk("t4_awready_low", {511'b0, bus.awready}, 0);
            chk("t4_wready_low", {511'b0, bus.wready}, 0);
            @(negedge aclk);
        end
        bus.awvalid = 0;
        chk("t4_regs", reg_q, exp_regs);
        bus.bready = 1;
        @(negedge aclk);
        bus.bready = 0;
        chk("t4_bvalid_clr", {511'b0, bus.bvalid}, 0);
        chk("t4_awready_back", {511'b0, bus.awready}, 1);
        chk("t4_wready_back", {511'b0, bus.wready}, 1);

        // 5: read collides with write commit to reg 3
        bus.wdata = 32'hA5A5A5A5; bus.wstrb = 4'hF; bus.wvalid = 1;
        @(negedge aclk);
        bus.wvalid = 0;
        bus.awaddr = 32'hC; bus.awvalid = 1;
        bus.araddr = 32'hC; bus.arvalid = 1;
        @(negedge aclk);
        bus.awvalid = 0; bus.arvalid = 0;
        exp_regs[127:96] = 32'hA5A5A5A5;
        chk("t5_bvalid", {511'b0, bus.bvalid}, 1);
        chk("t5_rvalid", {511'b0, bus.rvalid}, 1);
        chk("t5_rdata_old", {480'b0, bus.rdata}, 0);
        chk("t5_regs", reg_q, exp_regs);
        bus.bready = 1; bus.rready = 1;
        @(negedge aclk);
        bus.bready = 0; bus.rready = 0;
        do_read(32'hC, rd, resp);
        chk("t5_rdata_new", {480'b0, rd}, 32'hA5A5A5A5);
        chk("t5_rresp", {510'b0, resp}, 0);

        // 6: reset while a read response is pending
        bus.araddr = 32'h4; bus.arvalid = 1;
        @(negedge aclk);
        bus.arvalid = 0;
        chk("t6_rvalid_pending", {511'b0, bus.rvalid}, 1);
        @(posedge aclk);
        #2 aresetn = 1'b0;
        #1;
        chk("t6_rvalid_dropped", {511'b0, bus.rvalid}, 0);
        chk("t6_regs_cleared", reg_q, '0);
        chk("t6_arready_in_rst", {511'b0, bus.arready}, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("t6_arready_rel", {511'b0, bus.arready}, 1);
        chk("t6_awready_rel", {511'b0, bus.awready}, 1);
        chk("t6_rvalid_rel", {511'b0, bus.rvalid}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
